// File: rtl/dac714_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dac714_pkg
// Description : Shared definitions for the DAC714 serial output stage:
//               frame-sequencer state encoding, default frame width and the
//               width of the overrun counter.
// Revision    : 1.0  initial release
// ============================================================================
package dac714_pkg;

    localparam int DAC_WIDTH_DEFAULT = 16;
    localparam int OVR_CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LOAD     = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage : dac714_pkg
`default_nettype wire

// File: rtl/dac714_serial_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dac714_serial_if
// Description : Serialises the ramp generator's parallel setpoint into the
//               DAC714 three-wire port (SCLK / SDI / nLOAD), MSB first.
//               One pending word is buffered so that a strobe arriving while
//               a frame is being shifted is not lost; overwrites of an
//               unconsumed pending word are counted (saturating).
// Revision    : 1.0  initial release
//
// Ports
//   clk_slow     in   10 MHz clock, all logic on the rising edge
//   nReset       in   synchronous, active-low reset
//   strobe       in   update request; each rising edge is one request
//   data         in   signed setpoint, sampled on the strobe rising-edge cycle
//   dac_sclk     out  serial clock (DAC samples SDI on its rising edge)
//   dac_sdi      out  serial data, MSB first
//   dac_nload    out  active-low load pulse
//   busy         out  frame in progress or word pending
//   last_word    out  last word fully loaded into the DAC
//   overrun_cnt  out  saturating count of pending-word overwrites
// ============================================================================
module dac714_serial_if
    import dac714_pkg::*;
#(
    parameter int DAC_WIDTH     = DAC_WIDTH_DEFAULT,
    parameter int SCLK_HALF     = 1,
    parameter int LOAD_CYCLES   = 2,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic                 clk_slow,
    input  logic                 nReset,
    input  logic                 strobe,
    input  logic [DAC_WIDTH-1:0] data,
    output logic                 dac_sclk,
    output logic                 dac_sdi,
    output logic                 dac_nload,
    output logic                 busy,
    output logic [DAC_WIDTH-1:0] last_word,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);

    // One phase counter serves both the SCLK half-periods and the load pulse,
    // so it is sized for whichever of the two is longer.
    localparam int c_tc_max = (SCLK_HALF > LOAD_CYCLES) ? SCLK_HALF : LOAD_CYCLES;
    localparam int c_cnt_w  = (c_tc_max > 1) ? $clog2(c_tc_max) : 1;
    localparam int c_bit_w  = (DAC_WIDTH > 1) ? $clog2(DAC_WIDTH) : 1;

    localparam logic [c_cnt_w-1:0]   c_sclk_tc  = c_cnt_w'(SCLK_HALF - 1);
    localparam logic [c_cnt_w-1:0]   c_load_tc  = c_cnt_w'(LOAD_CYCLES - 1);
    localparam logic [c_bit_w-1:0]   c_bit_init = c_bit_w'(DAC_WIDTH - 1);
    localparam logic [OVR_CNT_W-1:0] c_ovr_max  = '1;

    state_t                 state_q, state_d;
    logic                   strobe_q, strobe_d;
    logic [DAC_WIDTH-1:0]   shift_q, shift_d;
    logic [DAC_WIDTH-1:0]   frame_q, frame_d;
    logic [c_bit_w-1:0]     bit_cnt_q, bit_cnt_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0]   pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   sclk_q, sclk_d;
    logic                   sdi_q, sdi_d;
    logic                   nload_q, nload_d;
    logic [DAC_WIDTH-1:0]   last_word_q, last_word_d;
    logic [OVR_CNT_W-1:0]   ovr_q, ovr_d;

    logic                   w_req;
    logic [DAC_WIDTH-1:0]   w_word;
    logic                   w_start;
    logic [DAC_WIDTH-1:0]   w_start_word;
    logic                   w_consume;
    logic                   w_capture;

    // Two's complement to offset binary is just an MSB flip.
    generate
        if (OFFSET_BINARY) begin : g_offset_binary
            assign w_word = {~data[DAC_WIDTH-1], data[DAC_WIDTH-2:0]};
        end else begin : g_twos_complement
            assign w_word = data;
        end
    endgenerate

    assign w_req = strobe & ~strobe_q;

    // Next-state / datapath
    always_comb begin
        state_d      = state_q;
        strobe_d     = strobe;
        shift_d      = shift_q;
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        last_word_d  = last_word_q;
        ovr_d        = ovr_q;
        w_start      = 1'b0;
        w_start_word = w_word;
        w_consume    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A word left pending by a request in the GAP cycle is
                // drained here before any new request.
                if (pend_valid_q) begin
                    w_start      = 1'b1;
                    w_start_word = pend_q;
                    w_consume    = 1'b1;
                end else if (w_req) begin
                    w_start      = 1'b1;
                    w_start_word = w_word;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_q == c_sclk_tc) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_q == c_sclk_tc) begin
                    cnt_d = '0;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        shift_d   = {shift_q[DAC_WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (cnt_q == c_load_tc) begin
                    cnt_d       = '0;
                    last_word_d = frame_q;
                    state_d     = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (pend_valid_q) begin
                    w_start      = 1'b1;
                    w_start_word = pend_q;
                    w_consume    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_start) begin
            state_d   = ST_SHIFT_LO;
            shift_d   = w_start_word;
            frame_d   = w_start_word;
            bit_cnt_d = c_bit_init;
            cnt_d     = '0;
        end

        // Any request not started directly goes into the pending slot. The
        // consume happens first, so a request in the same cycle as a drain
        // refills the slot without counting as an overrun.
        w_capture = w_req & ~((state_q == ST_IDLE) & ~pend_valid_q);
        if (w_consume) begin
            pend_valid_d = 1'b0;
        end
        if (w_capture) begin
            pend_d       = w_word;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !w_consume && (ovr_q != c_ovr_max)) begin
                ovr_d = ovr_q + 1'b1;
            end
        end

        // Pin drivers are registered from the next state so they are
        // glitch-free and aligned with the state they describe.
        sclk_d  = (state_d == ST_SHIFT_HI);
        nload_d = (state_d != ST_LOAD);
        sdi_d   = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ?
                  shift_d[DAC_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            strobe_q     <= 1'b0;
            shift_q      <= '0;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            sclk_q       <= 1'b0;
            sdi_q        <= 1'b0;
            nload_q      <= 1'b1;
            last_word_q  <= '0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            strobe_q     <= strobe_d;
            shift_q      <= shift_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            sclk_q       <= sclk_d;
            sdi_q        <= sdi_d;
            nload_q      <= nload_d;
            last_word_q  <= last_word_d;
            ovr_q        <= ovr_d;
        end
    end

    assign dac_sclk    = sclk_q;
    assign dac_sdi     = sdi_q;
    assign dac_nload   = nload_q;
    assign busy        = (state_q != ST_IDLE) | pend_valid_q;
    assign last_word   = last_word_q;
    assign overrun_cnt = ovr_q;

endmodule : dac714_serial_if
`default_nettype wire

// File: tb/tb_dac714_serial_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dac714_serial_if
// Description : Self-checking bench for dac714_serial_if. Two instances:
//               dut0 with default timing (two's complement), dut1 with
//               SCLK_HALF=3, LOAD_CYCLES=1, OFFSET_BINARY=1. Expected pin
//               waveforms are derived from each frame's start cycle and word.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dac714_serial_if;

    localparam int W   = 16;
    localparam int SH0 = 1;
    localparam int LC0 = 2;
    localparam int SH1 = 3;
    localparam int LC1 = 1;
    localparam int F0  = 2*SH0*W + LC0 + 1;
    localparam int F1  = 2*SH1*W + LC1 + 1;

    logic clk_slow = 1'b0;
    always #50 clk_slow = ~clk_slow;

    logic           nreset0, nreset1, strobe0, strobe1;
    logic [W-1:0]   data0, data1;
    logic           sclk0, sdi0, nload0, busy0;
    logic           sclk1, sdi1, nload1, busy1;
    logic [W-1:0]   lw0, lw1;
    logic [7:0]     ovr0, ovr1;

    dac714_serial_if #(.DAC_WIDTH(W), .SCLK_HALF(SH0), .LOAD_CYCLES(LC0), .OFFSET_BINARY(1'b0)) dut0 (
        .clk_slow(clk_slow), .nReset(nreset0), .strobe(strobe0), .data(data0),
        .dac_sclk(sclk0), .dac_sdi(sdi0), .dac_nload(nload0), .busy(busy0),
        .last_word(lw0), .overrun_cnt(ovr0)
    );

    dac714_serial_if #(.DAC_WIDTH(W), .SCLK_HALF(SH1), .LOAD_CYCLES(LC1), .OFFSET_BINARY(1'b1)) dut1 (
        .clk_slow(clk_slow), .nReset(nreset1), .strobe(strobe1), .data(data1),
        .dac_sclk(sclk1), .dac_sdi(sdi1), .dac_nload(nload1), .busy(busy1),
        .last_word(lw1), .overrun_cnt(ovr1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus schedule (strobe level / data per cycle) and expected frames.
    logic         stb_sched [0:511];
    logic [W-1:0] dat_sched [0:511];
    int           fr_start  [0:7];
    logic [W-1:0] fr_word   [0:7];
    int           n_fr;
    logic [W-1:0] lw_track0;
    logic [W-1:0] lw_track1;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr_sched();
        for (int i = 0; i < 512; i++) begin
            stb_sched[i] = 1'b0;
            dat_sched[i] = '0;
        end
        n_fr = 0;
    endtask

    task automatic add_frame(input int s, input logic [W-1:0] w);
        fr_start[n_fr] = s;
        fr_word[n_fr]  = w;
        n_fr++;
    endtask

    // Apply the schedule for ncyc cycles starting now (just after a rising
    // edge) and compare pins every cycle on the falling edge.
    task automatic run_scn(input int sel, input int ncyc, input logic [W-1:0] lw_init,
                           input bit final_chk, input logic [7:0] ovr_exp,
                           output logic [W-1:0] lw_out);
        int           sh, lc, f, rel, bitn;
        logic [W-1:0] lw, wk;
        logic         e_sclk, e_nload, e_sdi, in_fr, chk_sdi;
        logic         o_sclk, o_sdi, o_nload, o_busy;
        logic [W-1:0] o_lw;
        logic [7:0]   o_ovr;
        sh = (sel == 0) ? SH0 : SH1;
        lc = (sel == 0) ? LC0 : LC1;
        f  = 2*sh*W + lc + 1;
        lw = lw_init;
        for (int t = 0; t < ncyc; t++) begin
            if (sel == 0) begin
                strobe0 = stb_sched[t];
                data0   = dat_sched[t];
            end else begin
                strobe1 = stb_sched[t];
                data1   = dat_sched[t];
            end
            @(negedge clk_slow);
            e_sclk = 1'b0; e_nload = 1'b1; e_sdi = 1'b0; in_fr = 1'b0; chk_sdi = 1'b0;
            for (int k = 0; k < n_fr; k++) begin
                rel = t - fr_start[k];
                wk  = fr_word[k];
                if (rel >= 0 && rel < f) begin
                    in_fr = 1'b1;
                    if (rel < 2*sh*W) begin
                        bitn    = rel / (2*sh);
                        e_sclk  = ((rel % (2*sh)) >= sh);
                        e_sdi   = wk[W-1-bitn];
                        chk_sdi = 1'b1;
                    end else if (rel < 2*sh*W + lc) begin
                        e_nload = 1'b0;
                    end else begin
                        lw = wk;
                    end
                end
            end
            o_sclk  = (sel == 0) ? sclk0  : sclk1;
            o_sdi   = (sel == 0) ? sdi0   : sdi1;
            o_nload = (sel == 0) ? nload0 : nload1;
            o_busy  = (sel == 0) ? busy0  : busy1;
            o_lw    = (sel == 0) ? lw0    : lw1;
            chk("sclk", t, 32'(o_sclk), 32'(e_sclk));
            chk("nload", t, 32'(o_nload), 32'(e_nload));
            chk("last_word", t, 32'(o_lw), 32'(lw));
            if (chk_sdi) chk("sdi", t, 32'(o_sdi), 32'(e_sdi));
            if (in_fr)   chk("busy_in_frame", t, 32'(o_busy), 32'd1);
            @(posedge clk_slow); #1;
        end
        strobe0 = 1'b0;
        strobe1 = 1'b0;
        if (final_chk) begin
            @(negedge clk_slow);
            o_busy = (sel == 0) ? busy0 : busy1;
            o_ovr  = (sel == 0) ? ovr0  : ovr1;
            o_lw   = (sel == 0) ? lw0   : lw1;
            chk("busy_end", ncyc, 32'(o_busy), 32'd0);
            chk("overrun_end", ncyc, 32'(o_ovr), 32'(ovr_exp));
            chk("last_word_end", ncyc, 32'(o_lw), 32'(lw));
            @(posedge clk_slow); #1;
        end
        lw_out = lw;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b, c, d;
        int           plen;
        nreset0 = 1'b0; nreset1 = 1'b0;
        strobe0 = 1'b0; strobe1 = 1'b0;
        data0   = '0;   data1   = '0;
        repeat (3) @(posedge clk_slow);
        @(negedge clk_slow);
        // Reset values
        chk("rst_sclk0", 0, 32'(sclk0), 32'd0);
        chk("rst_sdi0", 0, 32'(sdi0), 32'd0);
        chk("rst_nload0", 0, 32'(nload0), 32'd1);
        chk("rst_busy0", 0, 32'(busy0), 32'd0);
        chk("rst_lw0", 0, 32'(lw0), 32'd0);
        chk("rst_ovr0", 0, 32'(ovr0), 32'd0);
        chk("rst_sclk1", 0, 32'(sclk1), 32'd0);
        chk("rst_nload1", 0, 32'(nload1), 32'd1);
        chk("rst_busy1", 0, 32'(busy1), 32'd0);
        chk("rst_lw1", 0, 32'(lw1), 32'd0);
        @(posedge clk_slow); #1;
        nreset0 = 1'b1; nreset1 = 1'b1;
        lw_track0 = '0;
        lw_track1 = '0;

        // Single update, 16'h8001
        clr_sched();
        stb_sched[0] = 1'b1; dat_sched[0] = 16'h8001;
        add_frame(1, 16'h8001);
        run_scn(0, F0 + 3, lw_track0, 1'b1, 8'd0, lw_track0);

        // Level-held strobe for 100 cycles gives exactly one frame
        clr_sched();
        for (int i = 0; i < 100; i++) begin
            stb_sched[i] = 1'b1; dat_sched[i] = 16'h1234;
        end
        add_frame(1, 16'h1234);
        run_scn(0, 104, lw_track0, 1'b1, 8'd0, lw_track0);

        // Random words, random strobe pulse length; data after the edge
        // cycle is scrambled to show it is sampled only on the edge cycle.
        for (int r = 0; r < 4; r++) begin
            clr_sched();
            d    = W'($urandom);
            plen = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) begin
                stb_sched[i] = (i < plen);
                dat_sched[i] = (i == 0) ? d : W'($urandom);
            end
            add_frame(1, d);
            run_scn(0, F0 + 1 + $urandom_range(1, 4), lw_track0, 1'b1, 8'd0, lw_track0);
        end

        // Strobes at 0, 10, 20: B overwritten by C, C follows A directly
        clr_sched();
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        stb_sched[0]  = 1'b1; dat_sched[0]  = a;
        stb_sched[10] = 1'b1; dat_sched[10] = b;
        stb_sched[20] = 1'b1; dat_sched[20] = c;
        add_frame(1, a);
        add_frame(F0 + 1, c);
        run_scn(0, 2*F0 + 4, lw_track0, 1'b1, 8'd1, lw_track0);

        // Reset in cycle 15 of a frame
        clr_sched();
        d = W'($urandom);
        stb_sched[0] = 1'b1; dat_sched[0] = d;
        add_frame(1, d);
        run_scn(0, 15, lw_track0, 1'b0, 8'd0, lw_track0);
        nreset0 = 1'b0;
        @(posedge clk_slow); #1;
        nreset0 = 1'b1;
        @(negedge clk_slow);
        chk("midrst_sclk", 16, 32'(sclk0), 32'd0);
        chk("midrst_sdi", 16, 32'(sdi0), 32'd0);
        chk("midrst_nload", 16, 32'(nload0), 32'd1);
        chk("midrst_busy", 16, 32'(busy0), 32'd0);
        chk("midrst_lw", 16, 32'(lw0), 32'd0);
        chk("midrst_ovr", 16, 32'(ovr0), 32'd0);
        @(posedge clk_slow); #1;
        // Partial frame must never produce a load pulse afterwards
        clr_sched();
        run_scn(0, 40, 16'h0000, 1'b1, 8'd0, lw_track0);
        // Following strobe gives a clean frame
        clr_sched();
        d = W'($urandom);
        stb_sched[0] = 1'b1; dat_sched[0] = d;
        add_frame(1, d);
        run_scn(0, F0 + 3, lw_track0, 1'b1, 8'd0, lw_track0);

        // Slow-SCLK, offset-binary instance: 0 -> 8000
        clr_sched();
        stb_sched[0] = 1'b1; dat_sched[0] = 16'h0000;
        add_frame(1, 16'h8000);
        run_scn(1, F1 + 3, lw_track1, 1'b1, 8'd0, lw_track1);
        for (int r = 0; r < 2; r++) begin
            clr_sched();
            d = W'($urandom);
            stb_sched[0] = 1'b1; dat_sched[0] = d;
            add_frame(1, d ^ 16'h8000);
            run_scn(1, F1 + 2, lw_track1, 1'b1, 8'd0, lw_track1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dac714_serial_if
`default_nettype wire
